// File: rtl/acc_pkg.sv
// acc_pkg: shared accumulator datapath width, operand type and sequencer state encoding
package acc_pkg;
  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, CLEAR} acc_ctrl_state_e;
endpackage

// File: rtl/acc_ctrl.sv
// acc_ctrl: burst sequencer that drives an accumulator and returns sum, beat count and overflow per burst
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  data_t            in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output data_t            out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            acc_a,
  output data_t            acc_b,
  output logic             acc_acc,
  output logic             acc_en_n,
  output logic             acc_rst_n,
  input  data_t            acc_y
);
  acc_ctrl_state_e  state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [DATA_W:0]  sum_w;
  logic             ovf;
  logic             fire;
  assign in_ready  = !clr && (state == IDLE || state == ACCUM);
  assign fire      = in_valid && in_ready;
  assign count_nx  = count + CNT_W'(1);
  assign sum_w     = {1'b0, acc_y} + {1'b0, in_data};
  assign acc_a     = fire ? in_data : '0;
  assign acc_b     = '0;
  assign acc_acc   = fire && state == ACCUM;
  assign acc_en_n  = !fire;
  assign acc_rst_n = rst_n && state != CLEAR;
  assign out_valid = state == DONE;
  assign out_sum   = acc_y;
  assign out_count = count;
  assign out_ovf   = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= CLEAR;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          count <= CNT_W'(1);
          ovf   <= 1'b0;
          state <= (in_last || MAX_LEN == 1) ? DONE : ACCUM;
        end
        ACCUM: if (fire) begin
          count <= count_nx;
          ovf   <= ovf | sum_w[DATA_W];
          state <= (in_last || count_nx == CNT_W'(MAX_LEN)) ? DONE : ACCUM;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
